// File: rtl/e203_ifu_pkg.sv
// Shared IFU types: instruction word width, default PC width
// and the buffered instruction entry.
package e203_ifu_pkg;

  localparam int IR_W     = 32;
  localparam int PC_W_DEF = 32;

  typedef struct packed {
    logic [IR_W-1:0]     ir;
    logic [PC_W_DEF-1:0] pc;
    logic                misalgn;
    logic                buserr;
    logic                prdt_taken;
  } ibuf_entry_t;

endpackage

// File: rtl/e203_ifu_ibuf_ctrl.sv
// IFU buffer pointer/occupancy control: read/write pointers,
// count, full/empty, with flush and reset clearing everything.
module e203_ifu_ibuf_ctrl #(
  parameter int DEPTH = 2,
  parameter int PW    = $clog2(DEPTH),
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          push,
  input  logic          pop,
  output logic [PW-1:0] wptr,
  output logic [PW-1:0] rptr,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);

  logic [PW-1:0] wptr_q, wptr_d;
  logic [PW-1:0] rptr_q, rptr_d;
  logic [CW-1:0] count_q, count_d;

  // next pointers/count; flush wins over push and pop
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (flush) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      if (push) wptr_d = wptr_q + PW'(1);
      if (pop)  rptr_d = rptr_q + PW'(1);
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  // state registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  assign wptr  = wptr_q;
  assign rptr  = rptr_q;
  assign count = count_q;
  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);

endmodule

// File: rtl/e203_ifu_ibuf.sv
// IFU-to-EXU instruction buffer (DEPTH entries, in order).
// Optional same-cycle bypass: E203_IFU_IBUF_BYPASS_EN.
module e203_ifu_ibuf
  import e203_ifu_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int PC_W  = PC_W_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_valid,
  output logic                  i_ready,
  input  logic [IR_W-1:0]       i_ir,
  input  logic [PC_W-1:0]       i_pc,
  input  logic                  i_misalgn,
  input  logic                  i_buserr,
  input  logic                  i_prdt_taken,
  output logic                  o_valid,
  input  logic                  o_ready,
  output logic [IR_W-1:0]       o_ir,
  output logic [PC_W-1:0]       o_pc,
  output logic                  o_misalgn,
  output logic                  o_buserr,
  output logic                  o_prdt_taken,
  input  logic                  flush,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PW = $clog2(DEPTH);

  logic [PW-1:0] wptr, rptr;
  logic          full, empty;
  logic          push, pop, byp;
  ibuf_entry_t   in_e, head;
  ibuf_entry_t   mem_q [DEPTH];
  ibuf_entry_t   mem_d [DEPTH];

  e203_ifu_ibuf_ctrl #(.DEPTH(DEPTH)) u_ctrl (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .push  (push),
    .pop   (pop),
    .wptr  (wptr),
    .rptr  (rptr),
    .count (count),
    .full  (full),
    .empty (empty)
  );

`ifdef E203_IFU_IBUF_BYPASS_EN
  assign byp = empty & i_valid & ~flush & ~rst;
`else
  assign byp = 1'b0;
`endif

  // handshake, bypass steering and head selection
  always_comb begin
    in_e            = '0;
    in_e.ir         = i_ir;
    in_e.pc         = PC_W_DEF'(i_pc);
    in_e.misalgn    = i_misalgn;
    in_e.buserr     = i_buserr;
    in_e.prdt_taken = i_prdt_taken;
    i_ready = ~full & ~flush & ~rst;
    o_valid = (~empty & ~flush & ~rst) | byp;
    // a bypassed instruction taken this cycle never enters storage
    push = i_valid & i_ready & ~(byp & o_ready);
    pop  = ~empty & ~flush & ~rst & o_ready;
    head = byp ? in_e : mem_q[rptr];
    o_ir         = head.ir;
    o_pc         = PC_W'(head.pc);
    o_misalgn    = head.misalgn;
    o_buserr     = head.buserr;
    o_prdt_taken = head.prdt_taken;
  end

  // storage write of the accepted entry
  always_comb begin
    mem_d = mem_q;
    if (push) mem_d[wptr] = in_e;
  end

  // payload storage, cleared on reset
  always_ff @(posedge clk) begin
    if (rst) mem_q <= '{default: '0};
    else     mem_q <= mem_d;
  end

endmodule

// File: tb/tb_e203_ifu_ibuf.sv
// Directed bench for e203_ifu_ibuf: a DEPTH=2 and a DEPTH=4
// instance share inputs; each task checks the relevant one.
module tb_e203_ifu_ibuf;

  logic        clk = 1'b0;
  logic        rst, flush, i_valid, o_ready;
  logic [31:0] i_ir, i_pc;
  logic        i_misalgn, i_buserr, i_prdt_taken;

  logic        a_ir_rdy, a_ov, a_mis, a_be, a_pt;
  logic [31:0] a_ir, a_pc;
  logic [1:0]  a_cnt;
  logic        b_ir_rdy, b_ov, b_mis, b_be, b_pt;
  logic [31:0] b_ir, b_pc;
  logic [2:0]  b_cnt;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  e203_ifu_ibuf #(.DEPTH(2)) u2 (
    .clk(clk), .rst(rst), .i_valid(i_valid), .i_ready(a_ir_rdy),
    .i_ir(i_ir), .i_pc(i_pc), .i_misalgn(i_misalgn),
    .i_buserr(i_buserr), .i_prdt_taken(i_prdt_taken),
    .o_valid(a_ov), .o_ready(o_ready), .o_ir(a_ir), .o_pc(a_pc),
    .o_misalgn(a_mis), .o_buserr(a_be), .o_prdt_taken(a_pt),
    .flush(flush), .count(a_cnt)
  );

  e203_ifu_ibuf #(.DEPTH(4)) u4 (
    .clk(clk), .rst(rst), .i_valid(i_valid), .i_ready(b_ir_rdy),
    .i_ir(i_ir), .i_pc(i_pc), .i_misalgn(i_misalgn),
    .i_buserr(i_buserr), .i_prdt_taken(i_prdt_taken),
    .o_valid(b_ov), .o_ready(o_ready), .o_ir(b_ir), .o_pc(b_pc),
    .o_misalgn(b_mis), .o_buserr(b_be), .o_prdt_taken(b_pt),
    .flush(flush), .count(b_cnt)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] pc);
    i_valid      = v;
    i_pc         = pc;
    i_ir         = pc ^ 32'h0000_0013;
    i_misalgn    = 1'b0;
    i_buserr     = 1'b0;
    i_prdt_taken = pc[2];
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; o_ready = 1'b0;
    drive(1'b0, 32'h0);
    step(); step();
    nvec++; if (a_cnt !== 2'd0) begin nerr++;
      $display("FAIL rst_count got %0d exp 0", a_cnt); end
    nvec++; if (a_ov !== 1'b0) begin nerr++;
      $display("FAIL rst_ovalid got %b exp 0", a_ov); end
    nvec++; if (a_ir_rdy !== 1'b0) begin nerr++;
      $display("FAIL rst_iready got %b exp 0", a_ir_rdy); end
    rst = 1'b0;
    #1;
    nvec++; if (a_ir_rdy !== 1'b1) begin nerr++;
      $display("FAIL post_rst_iready got %b exp 1", a_ir_rdy); end
    nvec++; if (a_ov !== 1'b0 || a_cnt !== 2'd0) begin nerr++;
      $display("FAIL post_rst_state got v=%b c=%0d exp v=0 c=0",
               a_ov, a_cnt); end
  endtask

  task automatic test_fill_drain();
    o_ready = 1'b0;
    drive(1'b1, 32'h8000_0000); step();
    drive(1'b1, 32'h8000_0004); step();
    drive(1'b0, 32'h0); #1;
    nvec++; if (a_cnt !== 2'd2) begin nerr++;
      $display("FAIL fill_count got %0d exp 2", a_cnt); end
    nvec++; if (a_ir_rdy !== 1'b0) begin nerr++;
      $display("FAIL fill_iready got %b exp 0", a_ir_rdy); end
    o_ready = 1'b1; #1;
    nvec++; if (a_ov !== 1'b1 || a_pc !== 32'h8000_0000) begin nerr++;
      $display("FAIL drain_first got v=%b pc=%h exp v=1 pc=80000000",
               a_ov, a_pc); end
    nvec++; if (a_ir !== 32'h8000_0013) begin nerr++;
      $display("FAIL drain_first_ir got %h exp 80000013", a_ir); end
    step();
    nvec++; if (a_ov !== 1'b1 || a_pc !== 32'h8000_0004) begin nerr++;
      $display("FAIL drain_second got v=%b pc=%h exp v=1 pc=80000004",
               a_ov, a_pc); end
    nvec++; if (a_pt !== 1'b1) begin nerr++;
      $display("FAIL drain_second_pt got %b exp 1", a_pt); end
    step();
    nvec++; if (a_cnt !== 2'd0 || a_ov !== 1'b0) begin nerr++;
      $display("FAIL drain_empty got c=%0d v=%b exp c=0 v=0",
               a_cnt, a_ov); end
    o_ready = 1'b0;
  endtask

  task automatic test_full_pop();
    o_ready = 1'b0;
    drive(1'b1, 32'h0000_2000); step();
    drive(1'b1, 32'h0000_2004); step();
    drive(1'b1, 32'h0000_2008);
    o_ready = 1'b1; #1;
    nvec++; if (a_ir_rdy !== 1'b0) begin nerr++;
      $display("FAIL fullpop_iready got %b exp 0", a_ir_rdy); end
    nvec++; if (a_ov !== 1'b1 || a_pc !== 32'h0000_2000) begin nerr++;
      $display("FAIL fullpop_head got v=%b pc=%h exp v=1 pc=00002000",
               a_ov, a_pc); end
    step();
    drive(1'b0, 32'h0); o_ready = 1'b0; #1;
    nvec++; if (a_cnt !== 2'd1 || a_pc !== 32'h0000_2004) begin nerr++;
      $display("FAIL fullpop_after got c=%0d pc=%h exp c=1 pc=00002004",
               a_cnt, a_pc); end
  endtask

  task automatic test_flush();
    o_ready = 1'b0;
    drive(1'b1, 32'h0000_200c); step();
    drive(1'b0, 32'h0); #1;
    nvec++; if (a_cnt !== 2'd2) begin nerr++;
      $display("FAIL flush_pre_count got %0d exp 2", a_cnt); end
    flush = 1'b1;
    drive(1'b1, 32'hdead_0000); #1;
    nvec++; if (a_ir_rdy !== 1'b0 || a_ov !== 1'b0) begin nerr++;
      $display("FAIL flush_cycle got r=%b v=%b exp r=0 v=0",
               a_ir_rdy, a_ov); end
    step();
    flush = 1'b0;
    drive(1'b0, 32'h0); #1;
    nvec++; if (a_cnt !== 2'd0 || a_ov !== 1'b0) begin nerr++;
      $display("FAIL flush_after got c=%0d v=%b exp c=0 v=0",
               a_cnt, a_ov); end
    nvec++; if (b_cnt !== 3'd0) begin nerr++;
      $display("FAIL flush_d4_count got %0d exp 0", b_cnt); end
    drive(1'b1, 32'h0000_3000); step();
    drive(1'b0, 32'h0); #1;
    nvec++; if (a_cnt !== 2'd1 || a_pc !== 32'h0000_3000) begin nerr++;
      $display("FAIL flush_next got c=%0d pc=%h exp c=1 pc=00003000",
               a_cnt, a_pc); end
    o_ready = 1'b1; step();
    o_ready = 1'b0; #1;
    nvec++; if (a_cnt !== 2'd0) begin nerr++;
      $display("FAIL flush_drain got %0d exp 0", a_cnt); end
  endtask

  task automatic test_wrap();
    int p = 0;
    int c = 0;
    int cyc = 0;
    logic acc;
    logic [31:0] epc;
    while (c < 10 && cyc < 300) begin
      drive(p < 10, 32'h0000_1000 + 32'(p) * 4);
      i_buserr  = (p == 6);
      i_misalgn = (p == 2);
      o_ready = ($urandom % 3) != 0;
      #1;
      acc = i_valid & b_ir_rdy;
      if (b_ov && o_ready) begin
        epc = 32'h0000_1000 + 32'(c) * 4;
        nvec++;
        if (b_pc !== epc || b_be !== (c == 6) || b_mis !== (c == 2)
            || b_ir !== (epc ^ 32'h13)) begin
          nerr++;
          $display("FAIL wrap_out%0d got pc=%h be=%b mis=%b exp pc=%h be=%b mis=%b",
                   c, b_pc, b_be, b_mis, epc, (c == 6), (c == 2));
        end
        c++;
      end
      step();
      if (acc) p++;
      cyc++;
    end
    nvec++;
    if (c != 10) begin
      nerr++;
      $display("FAIL wrap_timeout got %0d outputs exp 10", c);
    end
    drive(1'b0, 32'h0); i_buserr = 1'b0; i_misalgn = 1'b0;
    o_ready = 1'b1; step(); step(); step(); step(); step();
    o_ready = 1'b0; #1;
    nvec++; if (b_cnt !== 3'd0) begin nerr++;
      $display("FAIL wrap_final_count got %0d exp 0", b_cnt); end
  endtask

  task automatic test_reset_mid();
    o_ready = 1'b0;
    flush = 1'b1; step(); flush = 1'b0;
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 32'h0000_4000 + 32'(k) * 4); step();
    end
    drive(1'b1, 32'h0000_400c); #1;
    nvec++; if (b_cnt !== 3'd3) begin nerr++;
      $display("FAIL rstmid_pre got %0d exp 3", b_cnt); end
    rst = 1'b1; step();
    nvec++; if (b_cnt !== 3'd0 || b_ov !== 1'b0 || b_ir_rdy !== 1'b0)
      begin nerr++;
      $display("FAIL rstmid_clear got c=%0d v=%b r=%b exp c=0 v=0 r=0",
               b_cnt, b_ov, b_ir_rdy); end
    rst = 1'b0; drive(1'b0, 32'h0); #1;
    nvec++; if (b_ir_rdy !== 1'b1 || b_cnt !== 3'd0) begin nerr++;
      $display("FAIL rstmid_after got r=%b c=%0d exp r=1 c=0",
               b_ir_rdy, b_cnt); end
  endtask

  task automatic test_bypass();
    o_ready = 1'b1;
    drive(1'b1, 32'h0000_0100); #1;
`ifdef E203_IFU_IBUF_BYPASS_EN
    nvec++; if (a_ov !== 1'b1 || a_pc !== 32'h0000_0100) begin nerr++;
      $display("FAIL byp_same got v=%b pc=%h exp v=1 pc=00000100",
               a_ov, a_pc); end
    step();
    drive(1'b0, 32'h0); #1;
    nvec++; if (a_cnt !== 2'd0 || a_ov !== 1'b0) begin nerr++;
      $display("FAIL byp_count got c=%0d v=%b exp c=0 v=0",
               a_cnt, a_ov); end
`else
    nvec++; if (a_ov !== 1'b0) begin nerr++;
      $display("FAIL nobyp_same got v=%b exp 0", a_ov); end
    step();
    drive(1'b0, 32'h0); #1;
    nvec++; if (a_ov !== 1'b1 || a_pc !== 32'h0000_0100) begin nerr++;
      $display("FAIL nobyp_next got v=%b pc=%h exp v=1 pc=00000100",
               a_ov, a_pc); end
    step();
    nvec++; if (a_cnt !== 2'd0) begin nerr++;
      $display("FAIL nobyp_drain got %0d exp 0", a_cnt); end
`endif
    o_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_fill_drain();
    test_full_pop();
    test_flush();
    test_wrap();
    test_reset_mid();
    test_bypass();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
